// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display sharing one BCD-to-segment decoder.
// Ports:
//   clk, rst        - clock (rising edge), async active-high reset
//   enable          - 1 = scan, 0 = display off / idle
//   digits_in       - NDIGITS packed BCD digits, digit 0 in bits [3:0]
//   dp_in           - per-digit decimal point request (1 = lit)
//   lz_en           - 1 = suppress leading zeros
//   bcd             - BCD value for the shared decoder
//   an              - anode selects, active-low
//   dp_n            - decimal point, active-low
//   digit_idx       - index of the current digit slot
//   frame_done      - one-cycle pulse on the last cycle of a frame
module seg7_scan_ctrl #(
  parameter int unsigned NDIGITS      = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [4*NDIGITS-1:0]         digits_in,
  input  logic [NDIGITS-1:0]           dp_in,
  input  logic                         lz_en,
  output logic [3:0]                   bcd,
  output logic [NDIGITS-1:0]           an,
  output logic                         dp_n,
  output logic [$clog2(NDIGITS)-1:0]   digit_idx,
  output logic                         frame_done
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W = $clog2(NDIGITS);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                     state, state_n;
  logic [CNT_W-1:0]           cnt, cnt_n;
  logic [IDX_W-1:0]           idx, idx_n;
  logic [NDIGITS-1:0][3:0]    sh_d, sh_d_n;
  logic [NDIGITS-1:0]         sh_dp, sh_dp_n;
  logic                       sh_lz, sh_lz_n;
  logic [NDIGITS-1:0]         sup_n;
  logic [3:0]                 bcd_n;
  logic [NDIGITS-1:0]         an_n;
  logic                       dp_n_n;
  logic                       frame_done_n;

  // State, counters, shadow and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh_d       <= '0;
      sh_dp      <= '0;
      sh_lz      <= 1'b0;
      bcd        <= 4'd0;
      an         <= '1;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      sh_d       <= sh_d_n;
      sh_dp      <= sh_dp_n;
      sh_lz      <= sh_lz_n;
      bcd        <= bcd_n;
      an         <= an_n;
      dp_n       <= dp_n_n;
      frame_done <= frame_done_n;
    end
  end

  assign digit_idx = idx;

  // Next state; outputs are derived from next-cycle cnt/idx/shadow so the
  // registered outputs line up with the registered cnt/idx.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    idx_n        = idx;
    sh_d_n       = sh_d;
    sh_dp_n      = sh_dp;
    sh_lz_n      = sh_lz;
    sup_n        = '0;
    bcd_n        = 4'd0;
    an_n         = '1;
    dp_n_n       = 1'b1;
    frame_done_n = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (enable) begin
          state_n = SCAN;
          sh_d_n  = digits_in;
          sh_dp_n = dp_in;
          sh_lz_n = lz_en;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end else if (cnt == CNT_W'(PRESCALE - 1)) begin
          cnt_n = '0;
          if (idx == IDX_W'(NDIGITS - 1)) begin
            // Frame boundary: the only point where new inputs are taken
            idx_n   = '0;
            sh_d_n  = digits_in;
            sh_dp_n = dp_in;
            sh_lz_n = lz_en;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // A digit is blanked when it and every digit above it are zero
    begin : lz_scan
      logic all_zero;
      all_zero = 1'b1;
      for (int unsigned i = NDIGITS - 1; i >= 1; i--) begin
        all_zero = all_zero & (sh_d_n[i] == 4'd0);
        sup_n[i] = sh_lz_n & all_zero;
      end
    end

    if (state_n == SCAN) begin
      bcd_n        = sh_d_n[idx_n];
      frame_done_n = (cnt_n == CNT_W'(PRESCALE - 1)) && (idx_n == IDX_W'(NDIGITS - 1));
      if (cnt_n >= CNT_W'(BLANK_CYCLES)) begin
        if (!sup_n[idx_n]) an_n[idx_n] = 1'b0;
        dp_n_n = ~sh_dp_n[idx_n];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (NDIGITS=4, PRESCALE=8, BLANK_CYCLES=2).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        dp_n;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  seg7_scan_ctrl #(.NDIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in),
    .dp_in(dp_in), .lz_en(lz_en), .bcd(bcd), .an(an), .dp_n(dp_n),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [15:0]     digits;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][3:0] bcd_exp;  // per slot, slot 0 in [0]
    logic [3:0][3:0] an_exp;   // anode pattern after blanking, per slot
    logic [3:0]      dpn_exp;  // dp_n after blanking, bit = slot
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int c, input logic [3:0] eb,
                     input logic [3:0] ea, input logic ed, input logic [1:0] ei,
                     input logic ef);
    tests++;
    if ({bcd, an, dp_n, digit_idx, frame_done} !== {eb, ea, ed, ei, ef}) begin
      fails++;
      $display("FAIL %s cyc %0d: got bcd=%h an=%b dp_n=%b idx=%0d fd=%b, expected bcd=%h an=%b dp_n=%b idx=%0d fd=%b",
               name, c, bcd, an, dp_n, digit_idx, frame_done, eb, ea, ed, ei, ef);
    end
  endtask

  // Plain scan of a digit word with no dp and no suppression
  task automatic chk_norm(input string name, input int c, input logic [15:0] d, input int fd_cyc);
    int slot;
    logic [3:0] ea;
    slot = (c / 8) % 4;
    ea = ((c % 8) < 2) ? 4'b1111 : ~(4'b0001 << slot);
    chk(name, c, d[4*slot +: 4], ea, 1'b1, 2'(slot), c == fd_cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    #1 chk("reset", -1, 4'h0, 4'b1111, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; digits_in = 16'h0; dp_in = 4'h0; lz_en = 1'b0;

    vecs[0] = '{"plain_1234", 16'h1234, 4'b0000, 1'b0, {4'h1,4'h2,4'h3,4'h4},
                {4'b0111,4'b1011,4'b1101,4'b1110}, 4'b1111};
    vecs[1] = '{"dp_idx2", 16'h1234, 4'b0100, 1'b0, {4'h1,4'h2,4'h3,4'h4},
                {4'b0111,4'b1011,4'b1101,4'b1110}, 4'b1011};
    vecs[2] = '{"lz_0050", 16'h0050, 4'b0000, 1'b1, {4'h0,4'h0,4'h5,4'h0},
                {4'b1111,4'b1111,4'b1101,4'b1110}, 4'b1111};
    vecs[3] = '{"nolz_0050", 16'h0050, 4'b0000, 1'b0, {4'h0,4'h0,4'h5,4'h0},
                {4'b0111,4'b1011,4'b1101,4'b1110}, 4'b1111};
    vecs[4] = '{"lz_0500", 16'h0500, 4'b0000, 1'b1, {4'h0,4'h5,4'h0,4'h0},
                {4'b1111,4'b1011,4'b1101,4'b1110}, 4'b1111};
    vecs[5] = '{"lz_0000", 16'h0000, 4'b0000, 1'b1, {4'h0,4'h0,4'h0,4'h0},
                {4'b1111,4'b1111,4'b1111,4'b1110}, 4'b1111};
    vecs[6] = '{"lz_dp_sup", 16'h0007, 4'b1000, 1'b1, {4'h0,4'h0,4'h0,4'h7},
                {4'b1111,4'b1111,4'b1111,4'b1110}, 4'b0111};
    vecs[7] = '{"hex_abcd", 16'hABCD, 4'b0001, 1'b1, {4'hA,4'hB,4'hC,4'hD},
                {4'b0111,4'b1011,4'b1101,4'b1110}, 4'b1110};

    // Reset held: outputs at reset values across clock edges
    repeat (2) @(negedge clk);
    chk("reset_hold", -1, 4'h0, 4'b1111, 1'b1, 2'd0, 1'b0);

    // Table-driven full frames (plus first two cycles of the next frame)
    foreach (vecs[k]) begin
      do_reset();
      digits_in = vecs[k].digits; dp_in = vecs[k].dp; lz_en = vecs[k].lz;
      enable = 1'b1;
      for (int c = 0; c < 34; c++) begin
        int slot;
        logic blank;
        @(negedge clk);
        slot  = (c / 8) % 4;
        blank = (c % 8) < 2;
        chk(vecs[k].name, c, vecs[k].bcd_exp[slot],
            blank ? 4'b1111 : vecs[k].an_exp[slot],
            blank ? 1'b1 : vecs[k].dpn_exp[slot],
            2'(slot), c == 31);
      end
    end

    // digits_in change mid-frame takes effect only after the wrap
    do_reset();
    digits_in = 16'h1234; dp_in = 4'h0; lz_en = 1'b0; enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk_norm("midchange", c, (c < 32) ? 16'h1234 : 16'h9876, 31);
      if (c == 13) digits_in = 16'h9876;
    end

    // enable drop mid-frame, then re-enable with a fresh sample
    do_reset();
    digits_in = 16'h1234; enable = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      chk_norm("pre_drop", c, 16'h1234, 31);
    end
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("dropped", c, 4'h0, 4'b1111, 1'b1, 2'd0, 1'b0);
    end
    digits_in = 16'h5678; enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_norm("reenable", c, 16'h5678, 31);
    end

    // Async reset mid-frame, seen before any clock edge
    do_reset();
    digits_in = 16'h1234; enable = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      chk_norm("pre_rst", c, 16'h1234, 31);
    end
    #2 rst = 1'b1;
    #1 chk("async_rst", 10, 4'h0, 4'b1111, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_norm("post_rst", c, 16'h1234, 31);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
